// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-ported unified memory between the fetch stage (instruction
// reads) and the memory stage (data reads/writes). One transaction is in
// flight at a time. The data stage wins by default. Fetch is forced through
// after STARVE_MAX consecutive data wins against a pending fetch.
// Unaligned accesses and memory timeouts complete with err set.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   if_req/if_addr            fetch read request (level, held until if_done)
//   if_done/if_rdata          fetch completion pulse and read word
//   dm_req/dm_we/dm_addr/     data request (level, held until dm_done)
//   dm_wdata
//   dm_done/dm_rdata          data completion pulse and read word (0 on write)
//   mem_req/mem_we/mem_addr/  memory request, held until mem_gnt
//   mem_wdata
//   mem_gnt/mem_rvalid/       memory grant, response strobe and read data
//   mem_rdata
//   err                       pulses with done for unaligned or timed-out access
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; arbitrate among pending requests
// ISSUE  | mem_req high, waiting for mem_gnt
// WAIT   | granted, waiting for mem_rvalid
// RESP   | done (and err) pulse to the owner, then back to IDLE

module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    // Counter value during the TIMEOUT-th cycle spent in ISSUE+WAIT.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] S_MAX  = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic              owner_dm;
    logic [TW-1:0]     tcnt;
    logic [SW-1:0]     dm_streak;

    logic              fetch_wins;
    logic              pick_dm;
    logic [ADDR_W-1:0] sel_addr;
    logic              t_hit;

    // Completion of the current transaction this cycle: the next state is
    // RESP, and the done/err/rdata registers are loaded so they are visible
    // during the RESP cycle itself.
    logic              fin;
    logic              fin_err;
    logic              fin_dm;
    logic [DATA_W-1:0] fin_data;

    always_comb begin
        fetch_wins = if_req && (!dm_req || (dm_streak == S_MAX));
        pick_dm    = dm_req && !fetch_wins;
        sel_addr   = pick_dm ? dm_addr : if_addr;
        t_hit      = (tcnt == T_LAST);

        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_dm   = owner_dm;
        fin_data = '0;
        case (state)
            S_IDLE: begin
                fin_dm = pick_dm;
                if ((if_req || dm_req) && sel_addr[0]) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_ISSUE: begin
                if (t_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_WAIT: begin
                // A response arriving on the timeout cycle still counts.
                if (mem_rvalid) begin
                    fin = 1'b1;
                    if (!mem_we) begin
                        fin_data = mem_rdata;
                    end
                end else if (t_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner_dm  <= 1'b0;
            tcnt      <= '0;
            dm_streak <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_done <= fin && !fin_dm;
            dm_done <= fin && fin_dm;
            err     <= fin && fin_err;
            if (fin) begin
                if (fin_dm) begin
                    dm_rdata <= fin_data;
                end else begin
                    if_rdata <= fin_data;
                end
            end

            case (state)
                S_IDLE: begin
                    if (if_req || dm_req) begin
                        owner_dm  <= pick_dm;
                        mem_addr  <= sel_addr;
                        mem_we    <= pick_dm && dm_we;
                        mem_wdata <= pick_dm ? dm_wdata : '0;
                        tcnt      <= '0;
                        if (pick_dm) begin
                            if (if_req && (dm_streak != S_MAX)) begin
                                dm_streak <= dm_streak + SW'(1);
                            end
                        end else begin
                            dm_streak <= '0;
                        end
                        if (sel_addr[0]) begin
                            state <= S_RESP;
                        end else begin
                            state   <= S_ISSUE;
                            mem_req <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    tcnt <= tcnt + TW'(1);
                    if (t_hit) begin
                        mem_req <= 1'b0;
                        state   <= S_RESP;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tcnt <= tcnt + TW'(1);
                    if (mem_rvalid || t_hit) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 255;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          ifr;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dwe;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd;
        int            gd;       // cycles mem_gnt is withheld after mem_req rises
        int            rd;       // extra WAIT cycles before mem_rvalid
        logic [DW-1:0] mrd;
        logic          exp_dm;
        logic          exp_err;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_rd;
        int            exp_lat;  // done cycle, request first visible at cycle 0
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " if_done"},   32'(if_done),   0);
        chk({tag, " dm_done"},   32'(dm_done),   0);
        chk({tag, " err"},       32'(err),       0);
        chk({tag, " mem_req"},   32'(mem_req),   0);
        chk({tag, " mem_we"},    32'(mem_we),    0);
        chk({tag, " mem_addr"},  32'(mem_addr),  0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, " if_rdata"},  32'(if_rdata),  0);
        chk({tag, " dm_rdata"},  32'(dm_rdata),  0);
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b0;
        clear_inputs();
        #1;
        if (check) check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
    endtask

    // One isolated transaction from reset with a fixed memory schedule.
    task automatic run_vec(input vec_t v, input int idx);
        int done_cyc = -1;
        bit saw_req = 1'b0;
        do_reset(1'b0);
        if_req = v.ifr; if_addr = v.ia;
        dm_req = v.dr; dm_we = v.dwe; dm_addr = v.da; dm_wdata = v.dwd;
        for (int k = 1; k <= 20 && done_cyc < 0; k++) begin
            tick();
            if (mem_req) begin
                saw_req = 1'b1;
                chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.exp_addr));
                chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.exp_we));
                if (v.exp_we) chk($sformatf("v%0d mem_wdata", idx), 32'(mem_wdata), 32'(v.dwd));
            end
            if (if_done || dm_done) begin
                done_cyc = k;
                chk($sformatf("v%0d latency", idx), k, v.exp_lat);
                chk($sformatf("v%0d dm_done", idx), 32'(dm_done), 32'(v.exp_dm));
                chk($sformatf("v%0d if_done", idx), 32'(if_done), 32'(!v.exp_dm));
                chk($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
                chk($sformatf("v%0d rdata", idx), 32'(v.exp_dm ? dm_rdata : if_rdata), 32'(v.exp_rd));
                if_req = 1'b0; dm_req = 1'b0;
            end
            mem_gnt    = (k == 1 + v.gd);
            mem_rvalid = (k == 2 + v.gd + v.rd);
            mem_rdata  = mem_rvalid ? v.mrd : 16'($urandom);
        end
        if (done_cyc < 0) chk($sformatf("v%0d done within budget", idx), 0, 1);
        chk($sformatf("v%0d mem_req seen", idx), 32'(saw_req), 32'(!v.exp_err));
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
        chk($sformatf("v%0d single done", idx), 32'(if_done | dm_done), 0);
    endtask

    // Play memory for the next transaction: grant after g cycles of mem_req,
    // respond on the cycle after the grant. Returns in the done cycle.
    task automatic serve(input string nm, input int g, input logic [DW-1:0] data,
                         input logic exp_dm, input logic [AW-1:0] exp_addr,
                         input logic exp_we, input logic [DW-1:0] exp_wd,
                         input logic [DW-1:0] exp_rd);
        bit done = 1'b0;
        bit waiting = 1'b0;
        int gcnt = g;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (mem_req) begin
                chk({nm, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
                chk({nm, " mem_we"}, 32'(mem_we), 32'(exp_we));
                if (exp_we) chk({nm, " mem_wdata"}, 32'(mem_wdata), 32'(exp_wd));
            end
            if (if_done || dm_done) begin
                done = 1'b1;
                chk({nm, " owner"}, 32'(dm_done), 32'(exp_dm));
                chk({nm, " err"}, 32'(err), 0);
                chk({nm, " rdata"}, 32'(exp_dm ? dm_rdata : if_rdata), 32'(exp_rd));
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
            if (waiting) begin
                mem_rvalid = 1'b1; mem_rdata = data; waiting = 1'b0;
            end else if (mem_req && !done) begin
                if (gcnt == 0) begin mem_gnt = 1'b1; waiting = 1'b1; end
                else gcnt--;
            end
        end
        if (!done) chk({nm, " done within budget"}, 0, 1);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = 16'($urandom);
        a[0] = ($urandom_range(0, 7) == 0);
        return a;
    endfunction

    // Random traffic from both requesters against a transaction-level model:
    // at each arbitration point the winner follows the priority/starvation
    // rule, aligned requests complete one cycle after the memory response and
    // unaligned ones one cycle after the decision.
    task automatic run_random(input int n_txn);
        int cyc = 0, completed = 0, issued = 0;
        bit f_pend = 1'b0, d_pend = 1'b0;
        int f_gap, d_gap;
        bit busy = 1'b0;
        int free_at = 0, done_due = -1, phase = 0, g_cnt = 0, r_cnt = 0, streak = 0;
        logic e_dm = 1'b0, e_err = 1'b0, e_we = 1'b0;
        logic [AW-1:0] e_addr = '0;
        logic [DW-1:0] e_wd = '0, e_rd = '0;
        do_reset(1'b0);
        f_gap = $urandom_range(0, 3);
        d_gap = $urandom_range(0, 3);
        while (completed < n_txn && cyc < 20000) begin
            tick();
            cyc++;
            if (cyc == done_due) chk("rnd done pulse", 32'(if_done | dm_done), 1);
            if ((if_done || dm_done) && cyc != done_due) chk("rnd done timing", cyc, done_due);
            if (if_done || dm_done || cyc == done_due) begin
                if (if_done || dm_done) begin
                    chk("rnd dm_done", 32'(dm_done), 32'(e_dm));
                    chk("rnd if_done", 32'(if_done), 32'(!e_dm));
                    chk("rnd err", 32'(err), 32'(e_err));
                    chk("rnd rdata", 32'(e_dm ? dm_rdata : if_rdata), 32'(e_rd));
                end
                completed++;
                busy = 1'b0; free_at = cyc + 1; done_due = -1;
                if (e_dm) begin d_pend = 1'b0; d_gap = $urandom_range(0, 3); end
                else begin f_pend = 1'b0; f_gap = $urandom_range(0, 3); end
            end
            if (mem_req || phase == 1) chk("rnd mem_req", 32'(mem_req), 32'(phase == 1));
            if (mem_req) begin
                chk("rnd mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("rnd mem_we", 32'(mem_we), 32'(e_we));
                if (e_we) chk("rnd mem_wdata", 32'(mem_wdata), 32'(e_wd));
            end

            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
            case (phase)
                1: begin
                    if (g_cnt == 0) begin
                        mem_gnt = 1'b1; phase = 2; r_cnt = $urandom_range(0, 2);
                    end else g_cnt--;
                    mem_rvalid = ($urandom_range(0, 3) == 0);
                end
                2: begin
                    if (r_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        e_rd = e_we ? '0 : mem_rdata;
                        done_due = cyc + 1;
                        phase = 0;
                    end else begin
                        r_cnt--;
                        mem_gnt = ($urandom_range(0, 3) == 0);
                    end
                end
                default: begin
                    mem_gnt    = ($urandom_range(0, 3) == 0);
                    mem_rvalid = ($urandom_range(0, 3) == 0);
                end
            endcase

            if (!f_pend && issued < n_txn) begin
                if (f_gap == 0) begin f_pend = 1'b1; issued++; if_addr = rand_addr(); end
                else f_gap--;
            end
            if (!d_pend && issued < n_txn) begin
                if (d_gap == 0) begin
                    d_pend = 1'b1; issued++;
                    dm_addr = rand_addr(); dm_we = 1'($urandom); dm_wdata = 16'($urandom);
                end else d_gap--;
            end
            if_req = f_pend;
            dm_req = d_pend;

            if (!busy && cyc >= free_at && (f_pend || d_pend)) begin
                e_dm = d_pend && !(f_pend && streak == SM);
                if (e_dm) begin
                    if (f_pend && streak < SM) streak++;
                end else streak = 0;
                e_addr = e_dm ? dm_addr : if_addr;
                e_we   = e_dm ? dm_we : 1'b0;
                e_wd   = dm_wdata;
                e_err  = e_addr[0];
                busy   = 1'b1;
                if (e_err) begin
                    e_rd = '0; done_due = cyc + 1;
                end else begin
                    phase = 1; g_cnt = $urandom_range(0, 3);
                end
            end
        end
        chk("rnd completed", completed, n_txn);
        clear_inputs();
    endtask

    // Fetch that is granted at cycle 1 and answered (or not) at rv_cyc.
    task automatic timeout_run(input string nm, input int rv_cyc, input logic [DW-1:0] data,
                               input logic exp_err, input logic [DW-1:0] exp_rd);
        int done_cyc = -1;
        if_req = 1'b1; if_addr = 16'h0030;
        for (int k = 1; k <= 300 && done_cyc < 0; k++) begin
            tick();
            if (if_done || dm_done) begin
                done_cyc = k;
                chk({nm, " if_done"}, 32'(if_done), 1);
                chk({nm, " err"}, 32'(err), 32'(exp_err));
                chk({nm, " if_rdata"}, 32'(if_rdata), 32'(exp_rd));
                if_req = 1'b0;
            end
            mem_gnt    = (k == 1);
            mem_rvalid = (k == rv_cyc);
            mem_rdata  = mem_rvalid ? data : 16'($urandom);
        end
        chk({nm, " latency"}, done_cyc, TO + 1);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        #2;
        do_reset(1'b1);

        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0, 16'hA5C3,
                    1'b0, 1'b0, 1'b0, 16'h0010, 16'hA5C3, 3};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 0, 0, 16'h5A5A,
                    1'b1, 1'b0, 1'b0, 16'h0200, 16'h5A5A, 3};
        vecs[2] = '{1'b1, 16'h0020, 1'b1, 1'b1, 16'h0100, 16'h1234, 0, 0, 16'hDEAD,
                    1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 3};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0000, 0, 0, 16'h1111,
                    1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1};
        vecs[4] = '{1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0, 16'h2222,
                    1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1};
        vecs[5] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 3, 2, 16'hC001,
                    1'b0, 1'b0, 1'b0, 16'h0040, 16'hC001, 8};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0302, 16'h0000, 1, 1, 16'hFFFF,
                    1'b1, 1'b0, 1'b0, 16'h0302, 16'hFFFF, 5};
        vecs[7] = '{1'b1, 16'h0050, 1'b1, 1'b1, 16'h0009, 16'h7777, 0, 0, 16'h3333,
                    1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1};
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Simultaneous write and fetch: write first, then the fetch.
        do_reset(1'b0);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
        if_req = 1'b1; if_addr = 16'h0040;
        serve("sim write", 1, 16'hBBBB, 1'b1, 16'h0100, 1'b1, 16'h1234, 16'h0000);
        dm_req = 1'b0;
        serve("sim fetch", 0, 16'h3C3C, 1'b0, 16'h0040, 1'b0, 16'h0000, 16'h3C3C);
        if_req = 1'b0;

        // Starvation: four data wins, then fetch, and the pattern repeats.
        do_reset(1'b0);
        if_req = 1'b1; if_addr = 16'h0060;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0400;
        for (int i = 0; i < 10; i++) begin
            logic          edm;
            logic [DW-1:0] d;
            edm = (i % 5) != 4;
            d   = 16'(i * 257 + 1);
            serve($sformatf("starve%0d", i), i % 3, d, edm,
                  edm ? 16'(32'h0400 + 2 * i) : 16'(32'h0060 + 2 * i), 1'b0, 16'h0000, d);
            dm_addr = 16'(32'h0400 + 2 * (i + 1));
            if_addr = 16'(32'h0060 + 2 * (i + 1));
        end
        if_req = 1'b0; dm_req = 1'b0;

        // Timeout, response exactly on the timeout cycle, then normal service.
        do_reset(1'b0);
        if_req = 1'b1; if_addr = 16'h0070;
        serve("pre fetch", 0, 16'h9999, 1'b0, 16'h0070, 1'b0, 16'h0000, 16'h9999);
        if_req = 1'b0;
        tick();
        timeout_run("timeout", -1, 16'h0000, 1'b1, 16'h0000);
        tick();
        timeout_run("rvalid at limit", TO, 16'hBEEF, 1'b0, 16'hBEEF);
        if_req = 1'b1; if_addr = 16'h0032;
        serve("post timeout", 0, 16'h7777, 1'b0, 16'h0032, 1'b0, 16'h0000, 16'h7777);
        if_req = 1'b0;

        // Delayed grant keeps mem_* stable; reset in WAIT abandons the write.
        do_reset(1'b0);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h4321;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("dly mem_req c%0d", k), 32'(mem_req), 32'(k <= 4));
            if (k <= 4) begin
                chk($sformatf("dly mem_addr c%0d", k), 32'(mem_addr), 32'h0200);
                chk($sformatf("dly mem_wdata c%0d", k), 32'(mem_wdata), 32'h4321);
                chk($sformatf("dly mem_we c%0d", k), 32'(mem_we), 1);
            end
            mem_gnt = (k == 4);
        end
        mem_gnt = 1'b0;
        #2 rst = 1'b0;
        #1 check_outputs_zero("rst in wait");
        clear_inputs();
        mem_rvalid = 1'b1; mem_rdata = 16'hEEEE;
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("after rst no done", 32'(if_done | dm_done), 0);
            chk("after rst no mem_req", 32'(mem_req), 0);
        end

        // Reset during ISSUE drops mem_req at once.
        clear_inputs();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0210;
        tick();
        chk("issue mem_req", 32'(mem_req), 1);
        #2 rst = 1'b0;
        #1 chk("rst in issue mem_req", 32'(mem_req), 0);
        chk("rst in issue mem_addr", 32'(mem_addr), 0);
        clear_inputs();
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("after issue rst no done", 32'(if_done | dm_done), 0);
        end

        run_random(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported unified memory of the uRISC core between the fetch stage (instruction reads) and the memory stage (data reads and writes). It arbitrates one outstanding transaction at a time:
- issues it on the memory request/grant/response handshake;
- routes the response back to the owning stage;
- flags unaligned accesses and memory timeouts on `err`.

It sits between the fetch/mem stages and the memory model, instantiated in the core top.

## Interface
- `ADDR_W`, 16: byte-address width.
- `DATA_W`, 16: data word width.
- `TIMEOUT`, 255: max cycles spent in ISSUE+WAIT before abort (≥2).
- `STARVE_MAX`, 4: consecutive data-stage wins against a pending fetch before fetch is forced.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request; level, held until `if_done`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_done`  out  1  one-cycle completion pulse to fetch.
- `if_rdata`  out  DATA_W  fetched word; updated only with `if_done`.
- `dm_req`  in  1  data request; level, held until `dm_done`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  ADDR_W  data byte address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_done`  out  1  one-cycle completion pulse to mem stage.
- `dm_rdata`  out  DATA_W  read data; updated only with `dm_done` (0 for writes).
- `mem_req`  out  1  memory request; held until `mem_gnt`.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_gnt`  in  1  memory accepts request this cycle.
- `mem_rvalid`  in  1  response (read data or write ack), at least one cycle after `mem_gnt`.
- `mem_rdata`  in  DATA_W  response data.
- `err`  out  1  one-cycle pulse, coincident with the `done` of the faulting transaction.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE
- If any request is pending, pick a winner:
  - default: data stage wins.
  - starvation override: if `dm_streak == STARVE_MAX` and `if_req` is high, fetch wins.
- Latch owner, addr, we (fetch forces 0) and wdata.
- If latched `addr[0]` = 1, go to RESP with error set; no memory access.
- Otherwise go to ISSUE.

`dm_streak` counter
- Increments when the data stage wins while `if_req` = 1.
- Clears when fetch wins.
- Holds otherwise; saturates at STARVE_MAX.

ISSUE
- `mem_req` = 1; `mem_*` driven from latched registers, stable.
- On `mem_gnt`, go to WAIT.

WAIT
- On `mem_rvalid`, capture `mem_rdata` (reads only) and go to RESP.

Timeout
- A cycle counter clears on leaving IDLE and counts in ISSUE and WAIT.
- On reaching TIMEOUT, go to RESP with error set and response data 0.
- If `mem_rvalid` arrives in the same cycle the counter reaches TIMEOUT, `mem_rvalid` wins (no error).

RESP
- Pulse the owner's `done` for one cycle, plus `err` if error is set.
- Load the owner's rdata register.
- Return to IDLE.

Other rules
- `mem_gnt` outside ISSUE and `mem_rvalid` outside WAIT are ignored.
- Requesters must change or drop `req` in the cycle after `done`. IDLE samples one cycle after RESP, so a held request is never double-issued.

## Timing
- Reset (`rst` = 0, asynchronous) forces:
  - state IDLE;
  - `mem_req`, `mem_we`, `if_done`, `dm_done`, `err` = 0;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0;
  - `dm_streak` and timeout counter = 0.
- Reset mid-transaction abandons it: no `done` is issued, and `mem_req` drops immediately.
- Minimum latency, with the request first visible in IDLE at cycle 0:
  - cycle 1: ISSUE; `mem_req` = 1.
  - cycle 1: `mem_gnt` → WAIT at cycle 2.
  - cycle 2: `mem_rvalid` → `done` at cycle 3.
  - Total 4 cycles per transaction; maximum throughput is 1 transaction per 4 cycles.
- Unaligned access: `done` + `err` at cycle 1 (IDLE→RESP).
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Test plan
- Single fetch:
  - stimulus: `if_req` with `if_addr` = 0x0010; `mem_gnt` in cycle 1; `mem_rvalid` with `mem_rdata` = 0xA5C3 in cycle 2.
  - response: `mem_addr` = 0x0010, `mem_we` = 0; `if_done` pulse in cycle 3 with `if_rdata` = 0xA5C3; `err` = 0.
- Simultaneous requests:
  - stimulus: `if_req` and `dm_req` (write, addr 0x0100, data 0x1234) both asserted.
  - response: the write is issued first (`mem_we` = 1, 0x0100/0x1234), then `dm_done`; the fetch is issued next; `dm_rdata` = 0.
- Starvation override:
  - stimulus: `dm_req` re-asserted continuously with `if_req` held.
  - response: after 4 data wins the 5th grant goes to fetch; `dm_streak` = 0 afterwards.
- Unaligned access:
  - stimulus: `dm_req` with `dm_addr` = 0x0003.
  - response: `mem_req` never asserts; `dm_done` and `err` pulse together one cycle after the request; `dm_rdata` = 0.
- Timeout:
  - stimulus: `mem_gnt` given but no `mem_rvalid`.
  - response: `if_done` + `err` pulse after 255 cycles in ISSUE+WAIT; next request is served normally.
- Delayed grant and reset mid-transaction:
  - stimulus: `mem_gnt` delayed 3 cycles; then assert `rst` = 0 during WAIT.
  - response: `mem_addr` and `mem_wdata` stay stable while `mem_req` is high; on reset, all outputs go to 0 immediately and no `done` follows.
